// File: rtl/fb_arb_pkg.sv
// Shared types and defaults for the frame-buffer SRAM arbiter.
// Master ids double as tag FIFO payload and grant index.
package fb_arb_pkg;

    typedef enum logic [1:0] {
        M_DISP = 2'd0,
        M_PIX  = 2'd1,
        M_CPU  = 2'd2
    } mid_e;

    typedef enum logic {
        ARB_FREE = 1'b0,
        ARB_HELD = 1'b1
    } arb_st_e;

    localparam int unsigned GRANT_MAX_DEF = 4;
    localparam int unsigned MAX_PEND_DEF  = 4;

    // Round-robin successor over the three masters.
    function automatic mid_e mid_next(input mid_e m);
        mid_e r;
        unique case (m)
            M_DISP:  r = M_PIX;
            M_PIX:   r = M_CPU;
            default: r = M_DISP;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fb_arb_tag_fifo.sv
// In-order read tag FIFO: remembers which master owns each
// outstanding read so returning data can be steered back.
module fb_arb_tag_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0] mem_q [DEPTH];
    logic [PW-1:0] wp_q, rp_q;
    logic [PW:0] cnt_q;
    logic push_ok, pop_ok;

    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rp_q];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem_q[wp_q] <= din_i;
                wp_q        <= wp_q + 1'b1;
            end
            if (pop_ok) begin
                rp_q <= rp_q + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fb_sram_arbiter.sv
// Three-master Avalon-MM arbiter for the frame-buffer SRAM port:
// urgent display reads, short grant locks, round-robin fairness.
module fb_sram_arbiter
    import fb_arb_pkg::*;
#(
    parameter int unsigned AW        = 18,
    parameter int unsigned DW        = 16,
    parameter int unsigned GRANT_MAX = GRANT_MAX_DEF,
    parameter int unsigned MAX_PEND  = MAX_PEND_DEF
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            m0_read,
    input  logic [AW-1:0]   m0_address,
    input  logic            m0_urgent,
    output logic            m0_waitrequest,
    output logic [DW-1:0]   m0_readdata,
    output logic            m0_readdatavalid,
    input  logic            m1_write,
    input  logic [AW-1:0]   m1_address,
    input  logic [DW-1:0]   m1_writedata,
    input  logic [DW/8-1:0] m1_byteenable,
    output logic            m1_waitrequest,
    input  logic            m2_read,
    input  logic            m2_write,
    input  logic [AW-1:0]   m2_address,
    input  logic [DW-1:0]   m2_writedata,
    input  logic [DW/8-1:0] m2_byteenable,
    output logic            m2_waitrequest,
    output logic [DW-1:0]   m2_readdata,
    output logic            m2_readdatavalid,
    output logic            s_read,
    output logic            s_write,
    output logic [AW-1:0]   s_address,
    output logic [DW-1:0]   s_writedata,
    output logic [DW/8-1:0] s_byteenable,
    input  logic            s_waitrequest,
    input  logic [DW-1:0]   s_readdata,
    input  logic            s_readdatavalid,
    output logic            rdv_err
);

    localparam int unsigned LW = $clog2(GRANT_MAX + 1);
    localparam logic [LW-1:0] LOCK_MAX = LW'(GRANT_MAX);

    logic [2:0] req, is_rd, elig;
    logic fifo_full, fifo_empty;
    logic [1:0] fifo_head;

    arb_st_e st_q, st_d;
    mid_e hold_id_q, hold_id_d;
    mid_e owner_q, owner_d;
    mid_e rr_q, rr_d;
    logic [LW-1:0] lock_q, lock_d;
    logic err_q, err_d;

    logic gnt_vld;
    mid_e gnt_id;
    logic gnt_req, gnt_rd, accept, rdv_pop;

    // M2 read+write together is treated as a read.
    assign req   = {m2_read | m2_write, m1_write, m0_read};
    assign is_rd = {m2_read, 1'b0, 1'b1};
    // No new read may be issued while every tag slot is in use.
    assign elig  = req & ~(is_rd & {3{fifo_full}});

    // Grant choice: frozen while held, else urgency, lock, round-robin.
    always_comb begin
        mid_e cand;
        gnt_vld = 1'b0;
        gnt_id  = M_DISP;
        cand    = rr_q;
        if (st_q == ARB_HELD) begin
            gnt_vld = 1'b1;
            gnt_id  = hold_id_q;
        end else if (elig[M_DISP] && m0_urgent) begin
            gnt_vld = 1'b1;
            gnt_id  = M_DISP;
        end else if (elig[owner_q] && (lock_q < LOCK_MAX)) begin
            gnt_vld = 1'b1;
            gnt_id  = owner_q;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (!gnt_vld && elig[cand]) begin
                    gnt_vld = 1'b1;
                    gnt_id  = cand;
                end
                cand = mid_next(cand);
            end
        end
        if (sys_rst) begin
            gnt_vld = 1'b0;
        end
    end

    assign gnt_req = gnt_vld & req[gnt_id];
    assign gnt_rd  = is_rd[gnt_id];
    assign accept  = gnt_req & ~s_waitrequest;

    // Forward the granted master's request onto the slave port.
    always_comb begin
        s_address    = m0_address;
        s_writedata  = '0;
        s_byteenable = '1;
        unique case (gnt_id)
            M_DISP: begin
                s_address    = m0_address;
                s_writedata  = '0;
                s_byteenable = '1;
            end
            M_PIX: begin
                s_address    = m1_address;
                s_writedata  = m1_writedata;
                s_byteenable = m1_byteenable;
            end
            default: begin
                s_address    = m2_address;
                s_writedata  = m2_writedata;
                s_byteenable = m2_byteenable;
            end
        endcase
        s_read  = gnt_req & gnt_rd;
        s_write = gnt_req & ~gnt_rd;
    end

    assign m0_waitrequest = (gnt_vld && gnt_id == M_DISP) ? s_waitrequest : 1'b1;
    assign m1_waitrequest = (gnt_vld && gnt_id == M_PIX) ? s_waitrequest : 1'b1;
    assign m2_waitrequest = (gnt_vld && gnt_id == M_CPU) ? s_waitrequest : 1'b1;

    // Next-state for hold, ownership, lock run and rr pointer.
    always_comb begin
        st_d      = st_q;
        hold_id_d = hold_id_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        lock_d    = lock_q;
        err_d     = err_q;
        if (accept) begin
            st_d    = ARB_FREE;
            owner_d = gnt_id;
            // A regrant after an exhausted run starts a fresh run.
            if (gnt_id == owner_q && lock_q != LOCK_MAX) begin
                lock_d = lock_q + 1'b1;
            end else begin
                lock_d = LW'(1);
            end
            if (gnt_id != owner_q || lock_d == LOCK_MAX) begin
                rr_d = mid_next(gnt_id);
            end
        end else if (gnt_req) begin
            st_d      = ARB_HELD;
            hold_id_d = gnt_id;
        end
        if (s_readdatavalid && fifo_empty) begin
            err_d = 1'b1;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            st_q      <= ARB_FREE;
            hold_id_q <= M_DISP;
            owner_q   <= M_DISP;
            rr_q      <= M_DISP;
            lock_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            st_q      <= st_d;
            hold_id_q <= hold_id_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            lock_q    <= lock_d;
            err_q     <= err_d;
        end
    end

    fb_arb_tag_fifo #(
        .DEPTH (MAX_PEND),
        .W     (2)
    ) u_tags (
        .clk_i   (sys_clk),
        .rst_i   (sys_rst),
        .push_i  (accept & gnt_rd),
        .din_i   (gnt_id),
        .pop_i   (s_readdatavalid),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    assign rdv_pop = s_readdatavalid & ~fifo_empty;

    assign m0_readdatavalid = rdv_pop & (fifo_head == M_DISP);
    assign m2_readdatavalid = rdv_pop & (fifo_head == M_CPU);
    assign m0_readdata      = s_readdata;
    assign m2_readdata      = s_readdata;
    assign rdv_err          = err_q;

endmodule

// File: tb/tb_fb_sram_arbiter.sv
// Directed bench for fb_sram_arbiter with a per-cycle
// behavioural model and literal grant/return sequences.
module tb_fb_sram_arbiter;

    localparam int AW = 18;
    localparam int DW = 16;
    localparam int GM = 4;
    localparam int MP = 4;

    logic sys_clk, sys_rst;
    logic m0_read, m0_urgent, m0_waitrequest, m0_readdatavalid;
    logic [AW-1:0] m0_address;
    logic [DW-1:0] m0_readdata;
    logic m1_write, m1_waitrequest;
    logic [AW-1:0] m1_address;
    logic [DW-1:0] m1_writedata;
    logic [1:0] m1_byteenable;
    logic m2_read, m2_write, m2_waitrequest, m2_readdatavalid;
    logic [AW-1:0] m2_address;
    logic [DW-1:0] m2_writedata, m2_readdata;
    logic [1:0] m2_byteenable;
    logic s_read, s_write, s_waitrequest, s_readdatavalid;
    logic [AW-1:0] s_address;
    logic [DW-1:0] s_writedata, s_readdata;
    logic [1:0] s_byteenable;
    logic rdv_err;

    int total = 0;
    int bad = 0;

    int m_owner, m_lock, m_rr, m_hid;
    bit m_held, m_err;
    int tagq[$];
    int acc_log[$];
    int rdv_log[$];
    int expq[$];

    fb_sram_arbiter #(.AW(AW), .DW(DW), .GRANT_MAX(GM), .MAX_PEND(MP)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .m0_read(m0_read), .m0_address(m0_address), .m0_urgent(m0_urgent),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_write(m1_write), .m1_address(m1_address),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest),
        .m2_read(m2_read), .m2_write(m2_write), .m2_address(m2_address),
        .m2_writedata(m2_writedata), .m2_byteenable(m2_byteenable),
        .m2_waitrequest(m2_waitrequest), .m2_readdata(m2_readdata),
        .m2_readdatavalid(m2_readdatavalid),
        .s_read(s_read), .s_write(s_write), .s_address(s_address),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid), .rdv_err(rdv_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_q(input string nm, input int act[$], input int exp[$]);
        check({nm, "_len"}, act.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < act.size()) check(nm, act[i], exp[i]);
        end
    endtask

    // Model: spec arbitration rules evaluated from plain integers.
    always @(negedge sys_clk) begin : cmp
        int g, c, n;
        bit live, full;
        bit rq[3], rdm[3], el[3];
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [1:0] eb;
        if (sys_rst) begin
            m_owner = 0; m_lock = 0; m_rr = 0;
            m_held = 0; m_hid = 0; m_err = 0;
            tagq.delete();
            check("rst_s_read", s_read, 0);
            check("rst_s_write", s_write, 0);
            check("rst_wait0", m0_waitrequest, 1);
            check("rst_wait1", m1_waitrequest, 1);
            check("rst_wait2", m2_waitrequest, 1);
            check("rst_rdv0", m0_readdatavalid, 0);
            check("rst_rdv2", m2_readdatavalid, 0);
            check("rst_err", rdv_err, 0);
        end else begin
            rq[0] = m0_read; rq[1] = m1_write; rq[2] = m2_read | m2_write;
            rdm[0] = 1; rdm[1] = 0; rdm[2] = m2_read;
            full = (tagq.size() == MP);
            for (int i = 0; i < 3; i++) el[i] = rq[i] && !(rdm[i] && full);
            g = -1;
            if (m_held) g = m_hid;
            else if (el[0] && m0_urgent) g = 0;
            else if (el[m_owner] && m_lock < GM) g = m_owner;
            else begin
                for (int k = 0; k < 3; k++) begin
                    c = (m_rr + k) % 3;
                    if (g < 0 && el[c]) g = c;
                end
            end
            live = (g >= 0) && rq[g];
            check("s_read", s_read, live && rdm[g]);
            check("s_write", s_write, live && !rdm[g]);
            check("wait0", m0_waitrequest, (g == 0) ? s_waitrequest : 1'b1);
            check("wait1", m1_waitrequest, (g == 1) ? s_waitrequest : 1'b1);
            check("wait2", m2_waitrequest, (g == 2) ? s_waitrequest : 1'b1);
            if (live) begin
                ea = (g == 0) ? m0_address : (g == 1) ? m1_address : m2_address;
                check("s_address", s_address, ea);
                if (!rdm[g]) begin
                    ed = (g == 1) ? m1_writedata : m2_writedata;
                    eb = (g == 1) ? m1_byteenable : m2_byteenable;
                    check("s_writedata", s_writedata, ed);
                    check("s_byteenable", s_byteenable, eb);
                end
            end
            n = tagq.size();
            check("rdv0", m0_readdatavalid, s_readdatavalid && n > 0 && tagq[0] == 0);
            check("rdv2", m2_readdatavalid, s_readdatavalid && n > 0 && tagq[0] == 2);
            if (s_readdatavalid && n > 0) begin
                if (tagq[0] == 0) check("rdata0", m0_readdata, s_readdata);
                else check("rdata2", m2_readdata, s_readdata);
            end
            check("rdv_err", rdv_err, m_err);
            if ((s_read || s_write) && !s_waitrequest) begin
                acc_log.push_back(!m0_waitrequest ? 0 : !m1_waitrequest ? 1 :
                                  !m2_waitrequest ? 2 : 3);
            end
            if (m0_readdatavalid) rdv_log.push_back(int'(m0_readdata));
            if (m2_readdatavalid) rdv_log.push_back((2 << 16) | int'(m2_readdata));
            if (s_readdatavalid) begin
                if (n > 0) void'(tagq.pop_front());
                else m_err = 1;
            end
            if (live && !s_waitrequest) begin
                m_lock = (g == m_owner && m_lock != GM) ? m_lock + 1 : 1;
                if (g != m_owner || m_lock == GM) m_rr = (g + 1) % 3;
                m_owner = g;
                m_held = 0;
                if (rdm[g]) tagq.push_back(g);
            end else if (live) begin
                m_held = 1;
                m_hid = g;
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic clr_inputs();
        m0_read = 0; m0_urgent = 0; m0_address = '0;
        m1_write = 0; m1_address = '0; m1_writedata = '0; m1_byteenable = 2'b11;
        m2_read = 0; m2_write = 0; m2_address = '0; m2_writedata = '0;
        m2_byteenable = 2'b11;
        s_waitrequest = 0; s_readdata = '0; s_readdatavalid = 0;
    endtask

    task automatic do_reset();
        sys_rst = 1;
        clr_inputs();
        tick();
        tick();
        sys_rst = 0;
        acc_log.delete();
        rdv_log.delete();
    endtask

    initial begin
        sys_rst = 1;
        clr_inputs();
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst = 0;

        // Lone pixel writer streams six writes.
        acc_log.delete();
        for (int k = 0; k < 6; k++) begin
            m1_write = 1;
            m1_address = 18'h100 + 18'(k);
            m1_writedata = 16'hA000 + 16'(k);
            tick();
        end
        m1_write = 0;
        tick();
        expq = '{1, 1, 1, 1, 1, 1};
        chk_q("solo_m1", acc_log, expq);

        // Two writers alternate in runs of GRANT_MAX.
        do_reset();
        m1_write = 1; m1_writedata = 16'h1234;
        m2_write = 1; m2_address = 18'h200;
        m2_writedata = 16'h5555; m2_byteenable = 2'b01;
        repeat (12) tick();
        m1_write = 0; m2_write = 0;
        tick();
        expq = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 1, 1};
        chk_q("m1_m2_rr", acc_log, expq);

        // Urgent display read cannot preempt a held write.
        do_reset();
        m1_write = 1; m1_address = 18'h30;
        tick();
        tick();
        s_waitrequest = 1;
        tick();
        m0_read = 1; m0_urgent = 1; m0_address = 18'h300;
        tick();
        #1;
        check("held_m0_wait", m0_waitrequest, 1);
        check("held_s_write", s_write, 1);
        check("held_s_read", s_read, 0);
        tick();
        s_waitrequest = 0;
        tick();
        tick();
        m0_read = 0; m0_urgent = 0; m1_write = 0;
        tick();
        expq = '{1, 1, 1, 0};
        chk_q("urgent", acc_log, expq);

        // Interleaved reads return in order, latency 2.
        do_reset();
        m0_read = 1; m0_address = 18'h10;
        tick();
        m0_read = 0; m2_read = 1; m2_address = 18'h20;
        tick();
        m2_read = 0; m0_read = 1; m0_address = 18'h11;
        s_readdatavalid = 1; s_readdata = 16'h1111;
        tick();
        m0_read = 0; s_readdata = 16'h2222;
        tick();
        s_readdata = 16'h3333;
        tick();
        s_readdatavalid = 0;
        tick();
        expq = '{0, 2, 0};
        chk_q("rd_acc", acc_log, expq);
        expq = '{'h01111, 'h22222, 'h03333};
        chk_q("rd_ret", rdv_log, expq);

        // Full tag FIFO masks reads but not writes.
        do_reset();
        m0_read = 1;
        for (int k = 0; k < 4; k++) begin
            m0_address = 18'h40 + 18'(k);
            tick();
        end
        m0_read = 0;
        m2_read = 1; m2_address = 18'h50;
        m1_write = 1; m1_address = 18'h60; m1_writedata = 16'hBEEF;
        tick();
        m1_write = 0;
        s_readdatavalid = 1; s_readdata = 16'hAAAA;
        #1;
        check("full_m2_wait", m2_waitrequest, 1);
        check("full_s_read", s_read, 0);
        tick();
        s_readdatavalid = 0;
        tick();
        m2_read = 0;
        tick();
        for (int k = 0; k < 4; k++) begin
            s_readdatavalid = 1;
            s_readdata = 16'hB000 + 16'(k);
            tick();
        end
        s_readdatavalid = 0;
        tick();
        expq = '{0, 0, 0, 0, 1, 2};
        chk_q("full_acc", acc_log, expq);
        expq = '{'h0AAAA, 'h0B000, 'h0B001, 'h0B002, 'h2B003};
        chk_q("full_ret", rdv_log, expq);

        // Reset forgets reads; a stray return sets sticky rdv_err.
        do_reset();
        m0_read = 1; m0_address = 18'h77;
        tick();
        m0_read = 0;
        tick();
        sys_rst = 1;
        tick();
        sys_rst = 0;
        tick();
        check("err_after_rst", rdv_err, 0);
        s_readdatavalid = 1; s_readdata = 16'hDEAD;
        tick();
        s_readdatavalid = 0;
        tick();
        tick();
        check("err_sticky", rdv_err, 1);
        check("stray_rdv0", m0_readdatavalid, 0);
        sys_rst = 1;
        #1;
        check("err_cleared", rdv_err, 0);
        tick();
        sys_rst = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
